// File: rtl/tc_sram_hs.sv
// tc_sram_hs: multi-port SRAM with valid/ready requests and credited in-order responses.
// Define TC_SRAM_HS_ADDR_ERR_EN to flag addresses >= NoWords through rsp_err_o.
module tc_sram_hs #(
    parameter int NoWords   = 1024,
    parameter int DataWidth = 64,
    parameter int ByteWidth = 8,
    parameter int NoPorts   = 2,
    parameter int Latency   = 1,
    parameter int RspDepth  = Latency + 1,
    parameter     SimInit   = "none",
    localparam int AddrWidth = (NoWords > 1) ? $clog2(NoWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NoPorts-1:0]                  req_valid_i,
    output logic [NoPorts-1:0]                  req_ready_o,
    input  logic [NoPorts-1:0]                  we_i,
    input  logic [NoPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NoPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NoPorts-1:0][BeWidth-1:0]     be_i,
    output logic [NoPorts-1:0]                  rsp_valid_o,
    input  logic [NoPorts-1:0]                  rsp_ready_i,
    output logic [NoPorts-1:0][DataWidth-1:0]   rdata_o,
    output logic [NoPorts-1:0]                  rsp_err_o
);

    localparam int CntWidth = $clog2(RspDepth + 1);
    localparam int PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [DataWidth-1:0] mem [NoWords];

    logic [NoPorts-1:0]                acc;
    logic [NoPorts-1:0]                oor;
    logic [NoPorts-1:0]                wr_en;
    logic [NoPorts-1:0][DataWidth-1:0] rd_data;
    logic [NoPorts-1:0]                rd_err;
    logic                              rst_done;

    function automatic logic [DataWidth-1:0] init_word(input int w);
        logic [DataWidth-1:0] v;
        logic [31:0]          h;
        v = '0;
        h = 32'(w) ^ 32'h9E37_79B9;
        for (int b = 0; b < DataWidth; b++) begin
            if (b % 32 == 0) h = (h * 32'h0100_0193) ^ 32'h7F4A_7C15;
            if (SimInit == "ones") v[b] = 1'b1;
            else if (SimInit == "random") v[b] = h[5'(b)];
        end
        return v;
    endfunction

    // Read-first: data is sampled before this edge's writes land.
    always_comb begin
        acc     = '0;
        oor     = '0;
        wr_en   = '0;
        rd_data = '0;
        rd_err  = '0;
        for (int p = 0; p < NoPorts; p++) begin
            acc[p]   = req_valid_i[p] && req_ready_o[p];
            oor[p]   = 32'(addr_i[p]) >= 32'(NoWords);
            wr_en[p] = acc[p] && we_i[p] && !oor[p];
            if (acc[p] && !we_i[p] && !oor[p]) rd_data[p] = mem[addr_i[p]];
`ifdef TC_SRAM_HS_ADDR_ERR_EN
            rd_err[p] = acc[p] && oor[p];
`endif
        end
    end

    // Ports are applied in ascending order so the highest index wins a lane.
    if (SimInit == "none") begin : g_mem_noinit
        always_ff @(posedge clk_i) begin
            for (int p = 0; p < NoPorts; p++) begin
                if (wr_en[p]) begin
                    for (int b = 0; b < DataWidth; b++) begin
                        if (be_i[p][b / ByteWidth]) mem[addr_i[p]][b] <= wdata_i[p][b];
                    end
                end
            end
        end
    end else begin : g_mem_init
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int w = 0; w < NoWords; w++) mem[w] <= init_word(w);
            end else begin
                for (int p = 0; p < NoPorts; p++) begin
                    if (wr_en[p]) begin
                        for (int b = 0; b < DataWidth; b++) begin
                            if (be_i[p][b / ByteWidth]) mem[addr_i[p]][b] <= wdata_i[p][b];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_done <= 1'b0;
        else         rst_done <= 1'b1;
    end

    for (genvar p = 0; p < NoPorts; p++) begin : g_port
        logic [DataWidth-1:0] fifo_d [RspDepth];
        logic [RspDepth-1:0]  fifo_e;
        logic [PtrWidth-1:0]  wp;
        logic [PtrWidth-1:0]  rp;
        logic [CntWidth-1:0]  cnt;
        logic [CntWidth-1:0]  outst;
        logic                 push;
        logic                 pop;
        logic [DataWidth-1:0] push_d;
        logic                 push_e;

        // Latency-1 pipeline registers; the FIFO write supplies the last cycle.
        if (Latency == 1) begin : g_direct
            assign push   = acc[p];
            assign push_d = rd_data[p];
            assign push_e = rd_err[p];
        end else begin : g_pipe
            localparam int S = Latency - 1;
            logic [S-1:0]         pv;
            logic [S-1:0]         pe;
            logic [DataWidth-1:0] pd [S];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pv <= '0;
                end else begin
                    pv[0] <= acc[p];
                    for (int s = 1; s < S; s++) pv[s] <= pv[s-1];
                end
            end

            always_ff @(posedge clk_i) begin
                pd[0] <= rd_data[p];
                pe[0] <= rd_err[p];
                for (int s = 1; s < S; s++) begin
                    pd[s] <= pd[s-1];
                    pe[s] <= pe[s-1];
                end
            end

            assign push   = pv[S-1];
            assign push_d = pd[S-1];
            assign push_e = pe[S-1];
        end

        assign pop = rsp_valid_o[p] && rsp_ready_i[p];

        // Credits bound the FIFO occupancy, so push never meets a full FIFO.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wp    <= '0;
                rp    <= '0;
                cnt   <= '0;
                outst <= '0;
            end else begin
                if (push) wp <= (wp == PtrWidth'(RspDepth - 1)) ? '0 : wp + 1'b1;
                if (pop)  rp <= (rp == PtrWidth'(RspDepth - 1)) ? '0 : rp + 1'b1;
                cnt   <= cnt + CntWidth'(push) - CntWidth'(pop);
                outst <= outst + CntWidth'(acc[p]) - CntWidth'(pop);
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) begin
                fifo_d[wp] <= push_d;
                fifo_e[wp] <= push_e;
            end
        end

        assign rsp_valid_o[p] = cnt != '0;
        assign rdata_o[p]     = rsp_valid_o[p] ? fifo_d[rp] : '0;
        assign rsp_err_o[p]   = rsp_valid_o[p] && fifo_e[rp];
        assign req_ready_o[p] = rst_done && (outst < CntWidth'(RspDepth));
    end

endmodule

// File: tb/tb_tc_sram_hs.sv
// Bench for tc_sram_hs: queue-based response model plus directed scenarios.
// Out-of-range cases run only when TC_SRAM_HS_ADDR_ERR_EN is defined.
module tb_tc_sram_hs;

    localparam int NW  = 1000;
    localparam int DW  = 32;
    localparam int NP  = 2;
    localparam int LAT = 2;
    localparam int DEP = 2;
    localparam int AW  = 10;
    localparam int BW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NP-1:0]         req_valid;
    logic [NP-1:0]         req_ready;
    logic [NP-1:0]         we;
    logic [NP-1:0][AW-1:0] addr;
    logic [NP-1:0][DW-1:0] wdata;
    logic [NP-1:0][BW-1:0] be;
    logic [NP-1:0]         rsp_valid;
    logic [NP-1:0]         rsp_ready;
    logic [NP-1:0][DW-1:0] rdata;
    logic [NP-1:0]         rsp_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tc_sram_hs #(
        .NoWords  (NW),
        .DataWidth(DW),
        .ByteWidth(8),
        .NoPorts  (NP),
        .Latency  (LAT),
        .RspDepth (DEP),
        .SimInit  ("zeros")
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .be_i       (be),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rdata_o    (rdata),
        .rsp_err_o  (rsp_err)
    );

    // Model: every accepted request not yet dequeued, with its earliest visible cycle.
    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        longint        due;
    } exp_t;

    exp_t          q [NP][$];
    logic [DW-1:0] mm [NW];
    bit            ready_en = 1'b0;
    longint        cyc = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit m_ready(input int p);
        return ready_en && (q[p].size() < DEP);
    endfunction

    function automatic bit m_valid(input int p);
        return (q[p].size() > 0) && (q[p][0].due <= cyc);
    endfunction

    initial begin
        foreach (mm[w]) mm[w] = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        bit [NP-1:0]         acc;
        bit [NP-1:0]         deq;
        bit [NP-1:0]         bad;
        logic [NP-1:0][DW-1:0] rd;
        logic [NP-1:0]       er;
        int                  a;
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) q[p].delete();
            foreach (mm[w]) mm[w] = '0;
            ready_en = 1'b0;
            cyc = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                acc[p] = req_valid[p] && m_ready(p);
                deq[p] = m_valid(p) && rsp_ready[p];
            end
            cyc++;
            for (int p = 0; p < NP; p++) begin
                a = int'(addr[p]);
                bad[p] = a >= NW;
                rd[p] = '0;
                er[p] = 1'b0;
`ifdef TC_SRAM_HS_ADDR_ERR_EN
                er[p] = acc[p] && bad[p];
`endif
                if (acc[p] && !we[p] && !bad[p]) rd[p] = mm[a];
            end
            for (int p = 0; p < NP; p++) begin
                a = int'(addr[p]);
                if (acc[p] && we[p] && !bad[p])
                    for (int b = 0; b < DW; b++)
                        if (be[p][b / 8]) mm[a][b] = wdata[p][b];
            end
            for (int p = 0; p < NP; p++) begin
                if (deq[p]) void'(q[p].pop_front());
                if (acc[p]) q[p].push_back('{d: rd[p], e: er[p], due: cyc + LAT - 1});
            end
            ready_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        bit v;
        for (int p = 0; p < NP; p++) begin
            v = m_valid(p);
            chk($sformatf("ready%0d", p), req_ready[p], m_ready(p));
            chk($sformatf("rsp_valid%0d", p), rsp_valid[p], v);
            chk($sformatf("rdata%0d", p), rdata[p], v ? q[p][0].d : '0);
            chk($sformatf("rsp_err%0d", p), rsp_err[p], v ? q[p][0].e : 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_valid = '0;
        we = '0;
    endtask

    task automatic put(input int p, input bit w, input int a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
        req_valid[p] = 1'b1;
        we[p]        = w;
        addr[p]      = AW'(a);
        wdata[p]     = d;
        be[p]        = b;
    endtask

    task automatic drain();
        idle_all();
        rsp_ready = '1;
        repeat (6) step();
    endtask

    task automatic wait_rsp(input int p, input logic [DW-1:0] d, input bit e,
                            input string name);
        int n = 0;
        while (!rsp_valid[p] && n < 10) begin
            step();
            n++;
        end
        chk({name, "_valid"}, rsp_valid[p], 1'b1);
        chk(name, rdata[p], d);
        chk({name, "_err"}, rsp_err[p], e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        be        = '0;
        rsp_ready = '1;
        #1 rst_n = 1'b0;
        repeat (2) step();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_valid", rsp_valid, 2'b00);
        chk("rst_rdata", rdata, 64'h0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", req_ready, 2'b00);
        step();
        chk("ready_after_edge", req_ready, 2'b11);

        // Write then read on one port: two-cycle response latency.
        put(0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF);
        step();
        chk("wr_not_yet", rsp_valid[0], 1'b0);
        put(0, 1'b0, 5, '0, '0);
        step();
        chk("wr_rsp_valid", rsp_valid[0], 1'b1);
        chk("wr_rsp_data", rdata[0], 32'h0);
        idle_all();
        step();
        chk("rd_rsp_valid", rsp_valid[0], 1'b1);
        chk("rd_rsp_data", rdata[0], 32'hDEAD_BEEF);
        step();
        chk("rd_drained", rsp_valid[0], 1'b0);
        drain();

        // Read-first against a same-cycle write on the other port.
        put(0, 1'b1, 3, 32'h11, 4'hF);
        step();
        drain();
        put(0, 1'b0, 3, '0, '0);
        put(1, 1'b1, 3, 32'h22, 4'hF);
        step();
        idle_all();
        wait_rsp(0, 32'h11, 1'b0, "rf_old");
        drain();
        put(0, 1'b0, 3, '0, '0);
        step();
        idle_all();
        wait_rsp(0, 32'h22, 1'b0, "rf_new");
        drain();

        // Same-address write collision and disjoint byte lanes.
        put(0, 1'b1, 7, 32'hAAAA, 4'hF);
        put(1, 1'b1, 7, 32'h5555, 4'hF);
        step();
        put(0, 1'b1, 9, 32'h0000_00AA, 4'b0001);
        put(1, 1'b1, 9, 32'h0000_BB00, 4'b0010);
        step();
        drain();
        put(0, 1'b0, 7, '0, '0);
        put(1, 1'b0, 9, '0, '0);
        step();
        idle_all();
        wait_rsp(0, 32'h5555, 1'b0, "wr_prio");
        wait_rsp(1, 32'h0000_BBAA, 1'b0, "byte_lanes");
        drain();

        // Back-pressure: two credits, third request waits for a dequeue.
        rsp_ready[0] = 1'b0;
        put(0, 1'b0, 5, '0, '0);
        step();
        put(0, 1'b0, 7, '0, '0);
        step();
        chk("bp_ready_low", req_ready[0], 1'b0);
        put(0, 1'b0, 9, '0, '0);
        repeat (4) begin
            step();
            chk("bp_ready_hold", req_ready[0], 1'b0);
        end
        chk("bp_head", rdata[0], 32'hDEAD_BEEF);
        rsp_ready[0] = 1'b1;
        step();
        chk("bp_ready_back", req_ready[0], 1'b1);
        chk("bp_second", rdata[0], 32'h5555);
        step();
        idle_all();
        wait_rsp(0, 32'h0000_BBAA, 1'b0, "bp_third");
        drain();

        // Mixed two-port traffic with a fixed pattern of stalls.
        for (int i = 0; i < 48; i++) begin
            for (int p = 0; p < NP; p++) begin
                req_valid[p] = ((i + p) % 4) != 3;
                we[p]        = ((i * 3 + p) % 5) < 2;
                addr[p]      = AW'((i * 7 + p * 3) % 16);
                wdata[p]     = DW'(32'h1000_0000 * (p + 1) + i * 32'h0101);
                be[p]        = BW'(i * 5 + p);
            end
            rsp_ready[0] = (i % 3) != 2;
            rsp_ready[1] = (i % 5) != 4;
            step();
        end
        drain();

        // Reset with two responses queued.
        rsp_ready = '0;
        put(0, 1'b0, 5, '0, '0);
        step();
        put(0, 1'b0, 7, '0, '0);
        step();
        idle_all();
        repeat (3) step();
        chk("rq_two_valid", rsp_valid[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", rsp_valid, 2'b00);
        chk("rst_mid_ready", req_ready, 2'b00);
        chk("rst_mid_rdata", rdata, 64'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst2_ready", req_ready, 2'b11);
        chk("rst2_valid", rsp_valid, 2'b00);
        rsp_ready = '1;
        repeat (4) step();
        chk("no_stale", rsp_valid, 2'b00);
        put(0, 1'b0, 5, '0, '0);
        step();
        idle_all();
        wait_rsp(0, 32'h0, 1'b0, "reload_zero");
        drain();

`ifdef TC_SRAM_HS_ADDR_ERR_EN
        put(0, 1'b1, 999, 32'h1234, 4'hF);
        step();
        drain();
        put(1, 1'b1, 1010, 32'hFFFF_FFFF, 4'hF);
        step();
        idle_all();
        wait_rsp(1, 32'h0, 1'b1, "oor_wr");
        drain();
        put(0, 1'b0, 999, '0, '0);
        put(1, 1'b0, 1013, '0, '0);
        step();
        idle_all();
        wait_rsp(0, 32'h1234, 1'b0, "oor_keep");
        wait_rsp(1, 32'h0, 1'b1, "oor_rd");
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
